// File: rtl/rx_control_pkg.sv
// Shared types and widths for the UART receive-side word assembler.
package rx_control_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_HI  = 3'd1,
    WAIT_CHK = 3'd2,
    DONE     = 3'd3,
    TOUT     = 3'd4
  } state_t;

endpackage

// File: rtl/rx_byte_timer.sv
// Saturating inter-byte timer; expired is high while the count sits at TIMEOUT_CYCLES-1.
module rx_byte_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rx_control.sv
// Reassembles low-byte-first UART bytes into 16-bit words with inter-byte timeout.
// Optional third checksum byte (byte0 ^ byte1) enabled by defining RX_CHECKSUM_EN.
module rx_control
  import rx_control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] rx_data,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              timeout_err,
`ifdef RX_CHECKSUM_EN
  output logic              chk_err,
`endif
  output logic [2:0]        id
);

  state_t            state_q, state_d;
  logic [BYTE_W-1:0] byte0_q, byte0_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              dv_q, dv_d;
  logic              to_q, to_d;
  logic              expired;
  logic              waiting;
`ifdef RX_CHECKSUM_EN
  logic [BYTE_W-1:0] byte1_q, byte1_d;
  logic              chk_q, chk_d;
`endif

  // Every state consumes an arriving byte, so any rx_ready restarts the timer.
  assign waiting = (state_q == WAIT_HI) || (state_q == WAIT_CHK);

  rx_byte_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (rx_ready),
    .en      (waiting && !rx_ready),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    byte0_d    = byte0_q;
    data_out_d = data_out_q;
`ifdef RX_CHECKSUM_EN
    byte1_d    = byte1_q;
    chk_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (rx_ready) begin
          byte0_d = rx_data;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (rx_ready) begin
`ifdef RX_CHECKSUM_EN
          byte1_d = rx_data;
          state_d = WAIT_CHK;
`else
          data_out_d = {rx_data, byte0_q};
          state_d    = DONE;
`endif
        end else if (expired) begin
          state_d = TOUT;
        end
      end
`ifdef RX_CHECKSUM_EN
      WAIT_CHK: begin
        if (rx_ready) begin
          if (rx_data == (byte0_q ^ byte1_q)) begin
            data_out_d = {byte1_q, byte0_q};
            state_d    = DONE;
          end else begin
            chk_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (expired) begin
          state_d = TOUT;
        end
      end
`endif
      DONE, TOUT: begin
        if (rx_ready) begin
          byte0_d = rx_data;
          state_d = WAIT_HI;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    dv_d = (state_d == DONE);
    to_d = (state_d == TOUT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte0_q    <= '0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      to_q       <= 1'b0;
`ifdef RX_CHECKSUM_EN
      byte1_q    <= '0;
      chk_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      byte0_q    <= byte0_d;
      data_out_q <= data_out_d;
      dv_q       <= dv_d;
      to_q       <= to_d;
`ifdef RX_CHECKSUM_EN
      byte1_q    <= byte1_d;
      chk_q      <= chk_d;
`endif
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = dv_q;
  assign timeout_err = to_q;
  assign id          = state_q;
`ifdef RX_CHECKSUM_EN
  assign chk_err     = chk_q;
`endif

endmodule
